// File: rtl/exposure_timer.sv
// Exposure-time setting and exposure timer feeding the exposure/readout FSM.
// Times Exp_time*TICKS_PER_UNIT cycles after a Start edge and returns a one-cycle Ovf5.
module exposure_timer #(
    parameter int EXP_MIN        = 2,
    parameter int EXP_MAX        = 30,
    parameter int TICKS_PER_UNIT = 4,
    parameter int EXP_W          = 5
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Exp_increase,
    input  logic             Exp_decrease,
    output logic             Ovf5,
    output logic             Busy,
    output logic [EXP_W-1:0] Exp_time,
    output logic [EXP_W-1:0] Remaining
);

    localparam int PRE_W = $clog2(TICKS_PER_UNIT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_UNIT - 1);
    localparam logic [EXP_W-1:0] MIN_V    = EXP_W'(EXP_MIN);
    localparam logic [EXP_W-1:0] MAX_V    = EXP_W'(EXP_MAX);

    typedef enum logic [1:0] {IDLE, COUNT, DONE, WAIT_LOW} state_t;

    state_t           state_q, state_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [EXP_W-1:0] rem_q, rem_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             ovf_q, ovf_d;
    logic             start_prev_q, inc_prev_q, dec_prev_q;
    logic             start_armed_q;
    logic             start_edge, inc_edge, dec_edge;

    // Start held through reset must not look like a fresh edge; arm only after Start is seen low.
    assign start_edge = Start & ~start_prev_q & start_armed_q;
    assign inc_edge   = Exp_increase & ~inc_prev_q;
    assign dec_edge   = Exp_decrease & ~dec_prev_q;

    always_comb begin
        state_d = state_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        pre_d   = pre_q;
        ovf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (inc_edge && !dec_edge && exp_q < MAX_V) begin
                    exp_d = exp_q + 1'b1;
                end else if (dec_edge && !inc_edge && exp_q > MIN_V) begin
                    exp_d = exp_q - 1'b1;
                end
                if (start_edge) begin
                    rem_d   = exp_q;
                    pre_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!Start) begin
                    rem_d   = '0;
                    pre_d   = '0;
                    state_d = IDLE;
                end else if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    rem_d = rem_q - 1'b1;
                    if (rem_q == 1) begin
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            DONE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (!Start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= IDLE;
            exp_q         <= MIN_V;
            rem_q         <= '0;
            pre_q         <= '0;
            ovf_q         <= 1'b0;
            start_prev_q  <= 1'b0;
            inc_prev_q    <= 1'b0;
            dec_prev_q    <= 1'b0;
            start_armed_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            rem_q         <= rem_d;
            pre_q         <= pre_d;
            ovf_q         <= ovf_d;
            start_prev_q  <= Start;
            inc_prev_q    <= Exp_increase;
            dec_prev_q    <= Exp_decrease;
            start_armed_q <= start_armed_q | ~Start;
        end
    end

    assign Ovf5      = ovf_q;
    assign Busy      = (state_q != IDLE);
    assign Exp_time  = exp_q;
    assign Remaining = rem_q;

endmodule

// File: tb/tb_exposure_timer.sv
// Directed bench for exposure_timer: per-cycle vector table plus multi-cycle sequences.
module tb_exposure_timer;

    logic       Clk = 1'b0;
    logic       Reset, Start, Exp_increase, Exp_decrease;
    logic       Ovf5, Busy;
    logic [4:0] Exp_time, Remaining;

    int total = 0;
    int bad   = 0;

    exposure_timer #(
        .EXP_MIN(2), .EXP_MAX(30), .TICKS_PER_UNIT(4), .EXP_W(5)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .Exp_increase(Exp_increase), .Exp_decrease(Exp_decrease),
        .Ovf5(Ovf5), .Busy(Busy), .Exp_time(Exp_time), .Remaining(Remaining)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic rst, start, inc, dec;
        logic ovf, busy;
        int   expt, rem;
    } vec_t;

    vec_t vt[24];

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_inc();
        Exp_increase = 1'b1; step();
        Exp_increase = 1'b0; step();
    endtask

    task automatic pulse_dec();
        Exp_decrease = 1'b1; step();
        Exp_decrease = 1'b0; step();
    endtask

    // Accept a Start edge and time it to Ovf5; checks length, pulse width and release.
    task automatic run_exposure(input string name, input int units);
        int n;
        Start = 1'b1; step();
        chk({name, "_busy_on"}, Busy, 1);
        chk({name, "_rem_load"}, Remaining, units);
        n = 0;
        while (n < 200 && Ovf5 !== 1'b1) begin
            step();
            n++;
        end
        chk({name, "_cycles"}, n, units * 4);
        chk({name, "_rem_end"}, Remaining, 0);
        step();
        chk({name, "_ovf_width"}, Ovf5, 0);
        chk({name, "_busy_wait"}, Busy, 1);
        Start = 1'b0; step();
        chk({name, "_busy_off"}, Busy, 0);
    endtask

    initial begin
        int n;
        int seen_ovf;
        int busy_seen;
        Reset = 1'b1; Start = 1'b0; Exp_increase = 1'b0; Exp_decrease = 1'b0;

        //            rst   st    inc   dec   ovf   busy  exp rem
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vt[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 2};
        vt[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1};
        vt[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0};
        vt[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vt[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vt[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
        vt[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 0};
        vt[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3, 0};
        vt[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
        vt[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vt[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
        vt[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};
        vt[22] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0};
        vt[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0};

        for (int i = 0; i < 24; i++) begin
            Reset = vt[i].rst; Start = vt[i].start;
            Exp_increase = vt[i].inc; Exp_decrease = vt[i].dec;
            step();
            chk($sformatf("vec%0d_ovf", i), Ovf5, vt[i].ovf);
            chk($sformatf("vec%0d_busy", i), Busy, vt[i].busy);
            chk($sformatf("vec%0d_exp", i), Exp_time, vt[i].expt);
            chk($sformatf("vec%0d_rem", i), Remaining, vt[i].rem);
        end

        // Three increments, then a 5-unit exposure.
        for (int i = 0; i < 3; i++) pulse_inc();
        chk("inc3_exp", Exp_time, 5);
        run_exposure("exp5", 5);

        // A held button counts once.
        Exp_increase = 1'b1;
        for (int i = 0; i < 50; i++) step();
        Exp_increase = 1'b0; step();
        chk("held_inc", Exp_time, 6);
        pulse_dec();
        chk("dec_back", Exp_time, 5);

        // Button edges while busy are dropped, not queued.
        Start = 1'b1; step();
        chk("busy_btn_busy", Busy, 1);
        pulse_inc(); pulse_inc(); pulse_dec(); pulse_inc();
        chk("busy_btn_during", Exp_time, 5);
        n = 0;
        while (n < 100 && Ovf5 !== 1'b1) begin step(); n++; end
        chk("busy_btn_ovf_seen", Ovf5, 1);
        Start = 1'b0; step(); step(); step();
        chk("busy_btn_after", Exp_time, 5);
        chk("busy_btn_idle", Busy, 0);

        // Abort after 5 cycles of a 20-cycle exposure.
        Start = 1'b1; step();
        seen_ovf = 0;
        for (int i = 0; i < 4; i++) begin step(); if (Ovf5) seen_ovf = 1; end
        Start = 1'b0; step();
        chk("abort_busy", Busy, 0);
        chk("abort_rem", Remaining, 0);
        for (int i = 0; i < 25; i++) begin if (Ovf5) seen_ovf = 1; step(); end
        chk("abort_no_ovf", seen_ovf, 0);
        run_exposure("after_abort", 5);

        // Saturation at both ends.
        for (int i = 0; i < 40; i++) pulse_inc();
        chk("sat_max", Exp_time, 30);
        pulse_inc();
        chk("sat_max_hold", Exp_time, 30);
        for (int i = 0; i < 40; i++) pulse_dec();
        chk("sat_min", Exp_time, 2);
        pulse_dec();
        chk("sat_min_hold", Exp_time, 2);

        // Start edge and button edge together: load old value, update setting.
        Start = 1'b1; Exp_increase = 1'b1; step();
        chk("simul_rem", Remaining, 2);
        chk("simul_exp", Exp_time, 3);
        Start = 1'b0; Exp_increase = 1'b0; step();
        chk("simul_abort_idle", Busy, 0);

        // Reset mid-count with Exp_time=7; held Start must not retrigger.
        for (int i = 0; i < 4; i++) pulse_inc();
        chk("pre_reset_exp", Exp_time, 7);
        Start = 1'b1; step();
        for (int i = 0; i < 6; i++) step();
        Reset = 1'b1; step();
        chk("rst_busy", Busy, 0);
        chk("rst_exp", Exp_time, 2);
        chk("rst_ovf", Ovf5, 0);
        chk("rst_rem", Remaining, 0);
        Reset = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 10; i++) begin step(); if (Busy) busy_seen = 1; end
        chk("rst_start_held_ignored", busy_seen, 0);
        Start = 1'b0; step();
        run_exposure("post_reset", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/exposure_timer.md
Name: exposure_timer

Overview:
- Upstream neighbour of the exposure/readout control FSM.
- Holds the user-adjustable exposure time, set with increase/decrease push-buttons and kept between a minimum and a maximum.
- When the FSM raises Start, times the exposure and returns a single-cycle Ovf5 pulse. That pulse ends exposure in the FSM and hands over to readout.
- Only cycle-accurate timing source for exposure. All logic is on Clk.

Parameters:
- EXP_MIN, 2, minimum exposure setting in time units (reset value of the setting).
- EXP_MAX, 30, maximum exposure setting in time units.
- TICKS_PER_UNIT, 4, Clk cycles per time unit (real build: cycles per ms). Must be >= 2.
- EXP_W, 5, width of the setting and unit-counter registers. Must hold EXP_MAX.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Start  in  1  from the control FSM; high for the whole capture (exposure + readout).
- Exp_increase  in  1  push-button, level, already debounced; each rising edge requests +1.
- Exp_decrease  in  1  push-button, level, already debounced; each rising edge requests -1.
- Ovf5  out  1  one-cycle pulse marking end of exposure; to the FSM.
- Busy  out  1  high from Start edge acceptance until the timer returns to IDLE.
- Exp_time  out  EXP_W  current exposure setting.
- Remaining  out  EXP_W  whole time units left in the running exposure; 0 when not counting.

Behaviour:
- Reset is synchronous, active-high, with the same effect in every state:
  - State = IDLE; Ovf5=0; Busy=0; Remaining=0; prescaler=0.
  - Exp_time=EXP_MIN.
  - Edge-detect registers for Start, Exp_increase and Exp_decrease are cleared.
- Edge detect: each input has a previous-value register. A rising edge = input 1 this cycle and 0 last cycle. A held button produces exactly one request.
- Exp_time update (takes effect on the edge where the request is sampled):
  - Only in IDLE.
  - Increase edge alone: +1, saturating at EXP_MAX.
  - Decrease edge alone: -1, saturating at EXP_MIN.
  - Both edges in the same cycle: no change.
  - Requests arriving while Busy=1 are discarded, not queued.
- IDLE:
  - Busy=0.
  - Start rising edge: load Remaining=Exp_time, prescaler=0, Busy=1, go COUNT.
  - Start already high with no edge (e.g. after Reset with Start held): ignored.
- COUNT:
  - Prescaler increments every cycle.
  - When prescaler==TICKS_PER_UNIT-1: prescaler wraps to 0 and Remaining decrements.
  - When that wrap happens with Remaining==1: Remaining becomes 0, Ovf5=1, go DONE.
  - Latency: if the Start edge is accepted at clock edge n, Ovf5 is high during the cycle after edge n+Exp_time*TICKS_PER_UNIT. Exposure is exactly Exp_time*TICKS_PER_UNIT cycles.
  - Start low in any COUNT cycle: abort. Go IDLE, Remaining=0, prescaler=0, Busy=0, no Ovf5.
- DONE:
  - Ovf5 is high for exactly this one cycle.
  - Next state is WAIT_LOW, Ovf5=0.
- WAIT_LOW:
  - Busy stays 1 while the FSM does readout.
  - Start low: go IDLE, Busy=0.
  - No new exposure can begin until IDLE has seen a fresh Start rising edge.
- Simultaneous events:
  - Reset wins over everything.
  - A Start rising edge and a button edge in the same IDLE cycle: both take effect. The counter loads the pre-update Exp_time; the setting updates as normal.
- Ovf5 is registered (glitch-free), because the FSM uses it as an edge.
- Exp_time and Remaining are registered outputs.

Test Plan:
- Reset; Start rising edge at cycle 10, held high (TICKS_PER_UNIT=4, Exp_time=2) -> Busy=1 from cycle 11; Ovf5 high for exactly one cycle at cycle 19; Remaining steps 2,1,0; Start low at 30 -> Busy=0 at 31.
- Three separate Exp_increase pulses, then Start -> Exp_time=5; Ovf5 exactly 20 cycles after the accepted edge; one button held 50 cycles -> only +1.
- 40 increase pulses -> Exp_time=30, stays 30; then 40 decrease pulses -> Exp_time=2, stays 2; increase+decrease edges in the same cycle -> unchanged.
- Buttons pulsed while Busy=1 -> Exp_time unchanged, and still unchanged after returning to IDLE (not queued).
- Start dropped at cycle 5 of a 20-cycle exposure -> no Ovf5, Busy=0 next cycle; new Start edge -> full 20-cycle exposure.
- Reset asserted mid-COUNT with Exp_time=7 -> next cycle IDLE, Exp_time=2, Ovf5=0, Remaining=0; Start still high after Reset deasserts -> no exposure until Start falls and rises again.
